// File: rtl/bg_pkg.sv
// bg_pkg: shared FSM states, pixel layout and default sizes for the background line fetcher
package bg_pkg;
  localparam int DEF_LINE_PIXELS = 800;
  localparam int DEF_FRAME_LINES = 600;
  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_RAM_LAT = 1;
  typedef enum logic [1:0] {IDLE, CALC, FETCH, DRAIN} state_t;
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] r;
  } rgba_t;
endpackage

// File: rtl/bg_line_ram.sv
// bg_line_ram: one scanline buffer, simple dual-port with registered read
module bg_line_ram
  import bg_pkg::*;
#(
  parameter int DEPTH = DEF_LINE_PIXELS,
  parameter int WIDTH = DEF_DATA_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // independent write port and registered read port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/bg_line_fetcher.sv
// bg_line_fetcher: fetches a framebuffer scanline from SRAM into ping-pong line buffers and streams it as RGBA; scrolling via BG_SCROLL_EN
module bg_line_fetcher
  import bg_pkg::*;
#(
  parameter int LINE_PIXELS = DEF_LINE_PIXELS,
  parameter int FRAME_LINES = DEF_FRAME_LINES,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RAM_LAT = DEF_RAM_LAT
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [9:0]        fetch_line,
  input  logic [ADDR_W-1:0] fb_base,
  output logic              fetch_busy,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_din,
  output logic              ram_ce,
  output logic              ram_oe,
  output logic              ram_we,
  output logic              ram_lb,
  output logic              ram_hb,
  input  logic              line_start,
  input  logic              pix_en,
  input  logic              video_active,
`ifdef BG_SCROLL_EN
  input  logic [9:0]        scroll_x,
  input  logic [9:0]        scroll_y,
`endif
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic [3:0]        alpha,
  output logic              underrun
);
  localparam int CW = $clog2(LINE_PIXELS);
  localparam int DW = RAM_LAT > 1 ? $clog2(RAM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LINE_PIXELS - 1);
  localparam logic [DW-1:0] DLAST = DW'(RAM_LAT - 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(LINE_PIXELS);
  state_t state, nxt;
  logic [9:0] line_q;
  logic [ADDR_W-1:0] row_base;
  logic [CW-1:0] cnt, col, rd_ptr;
  logic [DW-1:0] dcnt;
  logic [10:0] eff_line, col0;
  logic [RAM_LAT-1:0] pv;
  logic [CW-1:0] pi [RAM_LAT];
  logic front, show, rsel, done, swap, rd_en;
  logic [1:0] valid;
  logic [DATA_W-1:0] q0, q1;
  rgba_t px;
`ifdef BG_SCROLL_EN
  localparam logic [10:0] LP11 = 11'(LINE_PIXELS);
  localparam logic [10:0] FL11 = 11'(FRAME_LINES);
  logic [10:0] sum_l, sx;
  assign sum_l = {1'b0, line_q} + {1'b0, scroll_y};
  assign sx = {1'b0, scroll_x};
  assign eff_line = sum_l >= FL11 ? sum_l - FL11 : sum_l;
  assign col0 = sx >= LP11 ? sx - LP11 : sx;
`else
  assign eff_line = {1'b0, line_q};
  assign col0 = '0;
`endif
  assign fetch_busy = state != IDLE;
  assign ram_ce = state == FETCH;
  assign ram_oe = ram_ce;
  assign ram_we = 1'b0;
  assign ram_lb = 1'b1;
  assign ram_hb = 1'b1;
  assign ram_addr = ram_ce ? row_base + ADDR_W'(col) : '0;
  assign done = state == DRAIN && dcnt == DLAST;
  assign swap = line_start && ((valid[~front] && !fetch_busy) || done);
  assign rd_en = pix_en && video_active;
  assign px = rsel ? q1[15:0] : q0[15:0];
  assign red = show ? px.r : '0;
  assign green = show ? px.g : '0;
  assign blue = show ? px.b : '0;
  assign alpha = show ? px.a : '0;
  // state register; reset aborts any fetch in progress
  always_ff @(posedge clk100) state <= rst ? IDLE : nxt;
  // one CALC cycle, LINE_PIXELS FETCH cycles, RAM_LAT DRAIN cycles
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = fetch_req ? CALC : IDLE;
      CALC:    nxt = FETCH;
      FETCH:   nxt = cnt == LAST ? DRAIN : FETCH;
      DRAIN:   nxt = done ? IDLE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  // row base, word index and wrapped column for the address stream
  always_ff @(posedge clk100) begin
    if (state == IDLE && fetch_req) line_q <= fetch_line;
    if (state == CALC) begin
      row_base <= fb_base + ADDR_W'(eff_line) * STRIDE;
      col <= CW'(col0);
      cnt <= '0;
    end
    if (state == FETCH) begin
      cnt <= cnt + 1'b1;
      col <= col == LAST ? '0 : col + 1'b1;
    end
    dcnt <= state == DRAIN ? dcnt + 1'b1 : '0;
  end
  // delay each issued word index by the SRAM latency so it meets its data
  always_ff @(posedge clk100) begin
    pv[0] <= ~rst & (state == FETCH);
    pi[0] <= cnt;
    for (int k = 1; k < RAM_LAT; k++) begin
      pv[k] <= ~rst & pv[k-1];
      pi[k] <= pi[k-1];
    end
  end
  // buffer ownership, valid flags, read pointer and underrun reporting
  always_ff @(posedge clk100) begin
    if (rst) begin
      front <= 1'b0;
      valid <= '0;
      rd_ptr <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= line_start && !swap;
      if (done) valid[~front] <= 1'b1;
      if (swap) begin
        front <= ~front;
        valid[front] <= 1'b0;
      end
      if (line_start) rd_ptr <= '0;
      else if (rd_en && rd_ptr != LAST) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  // colour stage remembers which buffer was read and whether it held a real line
  always_ff @(posedge clk100) begin
    show <= rst ? 1'b0 : !video_active ? 1'b0 : pix_en ? valid[front] : show;
    if (rd_en) rsel <= front;
  end
  bg_line_ram #(.DEPTH(LINE_PIXELS), .WIDTH(DATA_W)) buf0 (
    .clk(clk100), .we(pv[RAM_LAT-1] && front), .waddr(pi[RAM_LAT-1]), .wdata(ram_din),
    .re(rd_en && !front), .raddr(rd_ptr), .rdata(q0)
  );
  bg_line_ram #(.DEPTH(LINE_PIXELS), .WIDTH(DATA_W)) buf1 (
    .clk(clk100), .we(pv[RAM_LAT-1] && !front), .waddr(pi[RAM_LAT-1]), .wdata(ram_din),
    .re(rd_en && front), .raddr(rd_ptr), .rdata(q1)
  );
endmodule

// File: tb/tb_bg_line_fetcher.sv
// tb_bg_line_fetcher: randomized directed bench for bg_line_fetcher against a line-level reference model
module tb_bg_line_fetcher;
  localparam int LP = 800, FL = 600, AW = 18, DW = 16, LAT = 1;
  localparam int DONE_N = LP + LAT + 2;
  logic clk100 = 0, rst = 1, fetch_req = 0, line_start = 0, pix_en = 0, video_active = 0;
  logic [9:0] fetch_line = 0;
  logic [AW-1:0] fb_base = 0;
  logic fetch_busy, ram_ce, ram_oe, ram_we, ram_lb, ram_hb, underrun;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [15:0] salt = 0;
  logic [3:0] red, green, blue, alpha;
  int sx = 0, sy = 0;
  int checks = 0, errors = 0;
  logic [15:0] disp [LP];
  logic [15:0] pend [LP];
  bit disp_ok = 0, pend_ok = 0;
  logic [AW-1:0] seen [$];
`ifdef BG_SCROLL_EN
  logic [9:0] scroll_x = 0, scroll_y = 0;
`endif

  bg_line_fetcher dut (
    .clk100(clk100), .rst(rst), .fetch_req(fetch_req), .fetch_line(fetch_line), .fb_base(fb_base),
    .fetch_busy(fetch_busy), .ram_addr(ram_addr), .ram_din(ram_din), .ram_ce(ram_ce), .ram_oe(ram_oe),
    .ram_we(ram_we), .ram_lb(ram_lb), .ram_hb(ram_hb), .line_start(line_start), .pix_en(pix_en),
    .video_active(video_active),
`ifdef BG_SCROLL_EN
    .scroll_x(scroll_x), .scroll_y(scroll_y),
`endif
    .red(red), .green(green), .blue(blue), .alpha(alpha), .underrun(underrun)
  );

  always #5 clk100 = ~clk100;
  always @(posedge clk100) ram_din <= ram_addr[15:0] ^ salt;

  function automatic logic [AW-1:0] exp_addr(input int line, input logic [AW-1:0] base, input int i);
    int a;
    a = int'(base) + ((line + sy) % FL) * LP + (i + sx) % LP;
    return AW'(a);
  endfunction

  function automatic logic [15:0] rgba();
    return {alpha, blue, green, red};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic new_line(input string tag);
    bit exp_ur;
    exp_ur = !pend_ok;
    line_start = 1;
    tick();
    line_start = 0;
    check({tag, " underrun"}, 32'(underrun), 32'(exp_ur));
    if (!exp_ur) begin
      disp = pend;
      disp_ok = 1;
      pend_ok = 0;
    end
    tick();
    check({tag, " underrun pulse"}, 32'(underrun), 0);
  endtask

  task automatic read_px(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      pix_en = 1;
      video_active = 1;
      tick();
      check(tag, 32'(rgba()), disp_ok ? 32'(disp[k < LP ? k : LP - 1]) : 0);
    end
    pix_en = 0;
    video_active = 0;
    tick();
    check({tag, " blank"}, 32'(rgba()), 0);
  endtask

  task automatic do_fetch(input string tag, input int line, input logic [AW-1:0] base, input logic [15:0] s,
                          input int again_at, input int ls_at, input int abort_at);
    int n, idx, done_n;
    bit ur_exp;
    logic [AW-1:0] ea;
    logic [15:0] nd [LP];
    idx = 0;
    done_n = 0;
    ur_exp = 0;
    seen.delete();
    fetch_line = 10'(line);
    fb_base = base;
    salt = s;
    fetch_req = 1;
    tick();
    fetch_req = 0;
    n = 1;
    while (n < 2 * DONE_N && (fetch_busy || n <= ls_at + 1)) begin
      if (!fetch_busy && done_n == 0) done_n = n;
      fetch_req = n == again_at;
      if (n == ls_at) begin
        line_start = 1;
        ur_exp = n != DONE_N - 1;
      end
      if (n == ls_at + 1) begin
        line_start = 0;
        check({tag, " underrun"}, 32'(underrun), 32'(ur_exp));
      end
      if (ram_ce) begin
        if (idx == abort_at) begin
          rst = 1;
          tick();
          rst = 0;
          check({tag, " abort strobes"}, 32'({ram_ce, ram_oe, fetch_busy}), 0);
          disp_ok = 0;
          pend_ok = 0;
          return;
        end
        seen.push_back(ram_addr);
        check({tag, " addr"}, 32'({ram_oe, ram_addr}), 32'({1'b1, exp_addr(line, base, idx)}));
        idx++;
      end
      tick();
      n++;
    end
    fetch_req = 0;
    line_start = 0;
    if (done_n == 0) done_n = n;
    check({tag, " words"}, 32'(idx), 32'(LP));
    check({tag, " latency"}, 32'(done_n), 32'(DONE_N));
    for (int i = 0; i < LP; i++) begin
      ea = exp_addr(line, base, i);
      nd[i] = ea[15:0] ^ s;
    end
    if (ls_at == DONE_N - 1) begin
      disp = nd;
      disp_ok = 1;
      pend_ok = 0;
    end else begin
      pend = nd;
      pend_ok = 1;
    end
  endtask

  initial begin
    tick();
    tick();
    check("reset strobes", 32'({ram_ce, ram_oe, ram_we, fetch_busy, underrun}), 0);
    check("reset addr", 32'(ram_addr), 0);
    check("reset rgba", 32'(rgba()), 0);
    check("byte enables", 32'({ram_lb, ram_hb}), 32'h3);
    rst = 0;
    tick();
    new_line("boot");
    read_px("boot px", 4);
    do_fetch("line3", 3, '0, 16'h0, -1, -1, -1);
    new_line("line3");
    read_px("line3 px", 1000);
    repeat (3) begin
      do_fetch("rand", int'($urandom_range(0, FL - 1)), AW'($urandom), 16'($urandom), -1, -1, -1);
      new_line("rand");
      read_px("rand px", 20);
    end
    do_fetch("again", int'($urandom_range(0, FL - 1)), AW'($urandom), 16'($urandom), 300, -1, -1);
    new_line("again");
    read_px("again px", 10);
    do_fetch("late", int'($urandom_range(0, FL - 1)), AW'($urandom), 16'($urandom), -1, 100, -1);
    read_px("redisplay px", 10);
    new_line("after late");
    read_px("after late px", 10);
    do_fetch("coincide", int'($urandom_range(0, FL - 1)), AW'($urandom), 16'($urandom), -1, DONE_N - 1, -1);
    read_px("coincide px", 10);
    do_fetch("abort", 5, AW'($urandom), 16'($urandom), -1, -1, 400);
    new_line("after abort");
    read_px("after abort px", 10);
`ifdef BG_SCROLL_EN
    sx = 790;
    sy = 599;
    scroll_x = 10'd790;
    scroll_y = 10'd599;
    do_fetch("scroll", 1, '0, 16'($urandom), -1, -1, -1);
    check("scroll first addr", 32'(seen[0]), 32'd790);
    check("scroll 11th addr", 32'(seen[10]), 32'd0);
    new_line("scroll");
    read_px("scroll px", 30);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
